usb_reg_bridge: RTL and testbench
=================================

# usb_reg_bridge

- Parametrised register-bus bridge between the SAM3U external-memory USB interface and the FPGA register file, clocked on clk_usb.
- Generalises the existing USB register front end in three ways:
  - configurable data and address widths and synchronizer depth;
  - an explicit IDLE/WRITE/READ/STREAM state machine;
  - selectable byte-count wrap or saturate, plus a sticky protocol-error flag.
- Sits directly behind the USB pins; all register blocks hang off its reg_* bus.

## Interface
Parameters:
- pDATA_WIDTH, 8: width of the USB data bus and of reg_datao/reg_datai (8 or 16).
- pADDR_WIDTH, 8: width of cwusb_addr and reg_address.
- pBYTECNT_SIZE, 7: width of reg_bytecnt.
- pSYNC_STAGES, 2: synchronizer depth on rdn/wrn/alen (legal 1..3).
- pBYTECNT_SAT, 0: 0 = reg_bytecnt wraps at all-ones; 1 = reg_bytecnt saturates at all-ones.

Ports:
- clk_usb  in  1  USB-side clock.
- reset  in  1  synchronous, active-high.
- cwusb_din  in  pDATA_WIDTH  write data from USB chip.
- cwusb_dout  out  pDATA_WIDTH  read data to USB chip; combinational = reg_datai.
- cwusb_isout  out  1  data-bus output enable.
- cwusb_addr  in  pADDR_WIDTH  register address.
- cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen  in  1 each  active-low strobes, asynchronous to clk_usb.
- fast_fifo_read  in  1  request to hold the bus for FIFO streaming.
- reg_address  out  pADDR_WIDTH  cwusb_addr registered every cycle.
- reg_bytecnt  out  pBYTECNT_SIZE  byte index within the current address phase.
- reg_datao  out  pDATA_WIDTH  captured write data.
- reg_datai  in  pDATA_WIDTH  read data; must be valid 1 cycle after reg_read rises.
- reg_read  out  1  high while a read is active.
- reg_write  out  1  1-cycle write strobe; reg_datao is valid while it is high.
- proto_err  out  1  sticky: rdn and wrn were seen low together.
- proto_err_clr  in  1  clears proto_err.

## Operation
- Synchronizers:
  - rdn_s, wrn_s and alen_s are the pSYNC_STAGES-flop synchronized strobes.
  - Flops reset to 1 (inactive).
- FSM, one-hot or binary, states IDLE, WRITE, READ, STREAM:
  - IDLE -> WRITE when ~wrn_s & ~cwusb_cen.
  - Otherwise IDLE -> READ when ~rdn_s.
  - Otherwise IDLE -> STREAM on a rising edge of fast_fifo_read.
  - WRITE: reg_datao <= cwusb_din every cycle while ~wrn_s & ~cwusb_cen. When wrn_s = 1, reg_write pulses for 1 cycle and the FSM returns to IDLE.
  - READ: reg_read = 1. When rdn_s = 1, the FSM returns to IDLE and the output-enable hold cycle starts.
  - STREAM: reg_read = ~rdn_s & wrn_s. When ~wrn_s & ~cwusb_cen, the FSM goes to WRITE directly.
- Output enable:
  - cwusb_isout = isout_r | (stream_r & cwusb_wrn).
  - isout_r is registered and is high in READ plus exactly 1 hold cycle after leaving READ.
  - stream_r = state is STREAM. The raw cwusb_wrn term releases the bus combinationally, with no synchronizer delay, when the host starts a write.
- reg_bytecnt, in priority order:
  1. reset -> 0.
  2. ~alen_s -> 0.
  3. Otherwise increment once per completed transfer:
     - on the cycle after reg_write is high;
     - on the cycle rdn_s returns high in READ or STREAM.
  - At all-ones: wrap to 0 when pBYTECNT_SAT = 0; hold at all-ones when pBYTECNT_SAT = 1.
- Protocol error:
  - ~rdn_s & ~wrn_s in any state sets proto_err.
  - The write path takes priority; reg_read is forced to 0 that cycle.
  - proto_err_clr clears proto_err. A set in the same cycle wins over the clear.

## Timing
- Reset values:
  - Outputs: reg_address 0, reg_bytecnt 0, reg_datao 0, reg_read 0, reg_write 0, cwusb_isout 0, proto_err 0.
  - FSM in IDLE; stream_r 0.
- Latencies, with S = pSYNC_STAGES:
  - cwusb_rdn fall -> reg_read and cwusb_isout high after S+1 clk_usb edges.
  - cwusb_rdn rise -> reg_read low after S+1 edges; cwusb_isout low 1 edge later.
  - cwusb_wrn rise -> reg_write high for 1 cycle after S+1 edges.
  - reg_bytecnt updates 1 edge after reg_write.
  - reg_address follows cwusb_addr with 1-cycle latency.
- Reset mid-operation (any state): next edge gives IDLE and cwusb_isout = 0. No reg_write is issued for the interrupted write.
- A rising edge of fast_fifo_read outside IDLE is ignored, not queued.
- alen_s low concurrent with a transfer completion: the clear wins.

## Structure
- Package usb_reg_pkg holds:
  - the FSM state enum/localparams;
  - the legal-range checks for pSYNC_STAGES and pDATA_WIDTH;
  - the write-priority constants.
- Sub-module usb_sync_bit: an N-stage synchronizer with a reset-value parameter. It is instantiated for rdn, wrn and alen.

## Test plan
- Single write: with S=2, addr 0x12, din 0xA5, pulse wrn low 4 cycles -> reg_datao = 0xA5, a single 1-cycle reg_write 3 edges after wrn rises, reg_bytecnt 0->1.
- Read burst: alen low then high, 3 rdn pulses -> reg_read asserted 3 times, cwusb_isout ends 1 cycle after each reg_read, reg_bytecnt = 3; alen low -> 0.
- Byte-count boundary: pBYTECNT_SIZE=3, 9 writes -> reg_bytecnt 1 with pBYTECNT_SAT=0, 7 with pBYTECNT_SAT=1.
- Stream: raise fast_fifo_read -> cwusb_isout 1 with rdn idle; drop cwusb_wrn -> cwusb_isout 0 in the same cycle (combinational), FSM in WRITE after S+1 edges.
- Protocol error: rdn and wrn low together -> proto_err 1, reg_read 0, write completes; proto_err_clr -> proto_err 0.
- Reset during READ: cwusb_isout 0 and reg_read 0 after 1 edge, reg_bytecnt 0, no increment on the later rdn rise.

Source files
------------

// File: rtl/usb_reg_pkg.sv
// -----------------------------------------------------------------------------
// usb_reg_pkg
// Shared definitions for the USB register bridge:
//   - FSM state encodings (binary, legacy-compatible localparams)
//   - rd/wr collision priority constant
//   - legal-range checks for the bridge parameters
// No ports (package).
// -----------------------------------------------------------------------------
package usb_reg_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  // When rdn and wrn are both seen low, the write path wins and the
  // read strobe toward the register file is suppressed.
  localparam logic WR_OVER_RD = 1'b1;

  // Synchronizer depth must be 1..3 flops.
  function automatic logic sync_stages_ok(input int n);
    return (n >= 1) && (n <= 3);
  endfunction

  // USB data bus is either 8 or 16 bits wide.
  function automatic logic data_width_ok(input int w);
    return (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/usb_sync_bit.sv
// -----------------------------------------------------------------------------
// usb_sync_bit
// N-stage single-bit synchronizer with a configurable reset value.
// Ports:
//   clk_usb  in   destination clock
//   reset    in   synchronous, active-high; all stages load RST_VAL
//   d        in   asynchronous input
//   q        out  synchronized output (last stage)
// -----------------------------------------------------------------------------
module usb_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_usb,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain; stage 0 samples the asynchronous input.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/usb_reg_bridge.sv
// -----------------------------------------------------------------------------
// usb_reg_bridge
// Bridge between the SAM3U external-memory USB interface and the FPGA
// register bus, clocked on clk_usb.
// Ports:
//   clk_usb, reset             clock, synchronous active-high reset
//   cwusb_din/dout/isout       USB data bus in/out and output enable
//   cwusb_addr                 register address from the USB chip
//   cwusb_rdn/wrn/cen/alen     active-low strobes (asynchronous)
//   fast_fifo_read             rising edge in IDLE enters STREAM mode
//   reg_address/bytecnt        register address and byte index
//   reg_datao/datai            write data out / read data in
//   reg_read/reg_write         read level / 1-cycle write strobe
//   proto_err/proto_err_clr    sticky rd+wr collision flag and its clear
// -----------------------------------------------------------------------------
module usb_reg_bridge
  import usb_reg_pkg::*;
#(
  parameter int pDATA_WIDTH   = 8,
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSYNC_STAGES  = 2,
  parameter int pBYTECNT_SAT  = 0
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic [pDATA_WIDTH-1:0]   cwusb_din,
  output logic [pDATA_WIDTH-1:0]   cwusb_dout,
  output logic                     cwusb_isout,
  input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
  input  logic                     cwusb_rdn,
  input  logic                     cwusb_wrn,
  input  logic                     cwusb_cen,
  input  logic                     cwusb_alen,
  input  logic                     fast_fifo_read,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [pDATA_WIDTH-1:0]   reg_datao,
  input  logic [pDATA_WIDTH-1:0]   reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     proto_err,
  input  logic                     proto_err_clr
);

  if (!sync_stages_ok(pSYNC_STAGES)) begin : g_bad_sync
    $error("usb_reg_bridge: pSYNC_STAGES must be 1..3");
  end
  if (!data_width_ok(pDATA_WIDTH)) begin : g_bad_width
    $error("usb_reg_bridge: pDATA_WIDTH must be 8 or 16");
  end

  localparam logic [pBYTECNT_SIZE-1:0] BC_ONE  = pBYTECNT_SIZE'(1'b1);
  localparam logic [pBYTECNT_SIZE-1:0] BC_MAX  = {pBYTECNT_SIZE{1'b1}};
  localparam logic                     BC_SAT  = (pBYTECNT_SAT != 0);

  logic w_rdn_s, w_wrn_s, w_alen_s;

  usb_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b1)) u_sync_rdn (
    .clk_usb(clk_usb), .reset(reset), .d(cwusb_rdn), .q(w_rdn_s));
  usb_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b1)) u_sync_wrn (
    .clk_usb(clk_usb), .reset(reset), .d(cwusb_wrn), .q(w_wrn_s));
  usb_sync_bit #(.STAGES(pSYNC_STAGES), .RST_VAL(1'b1)) u_sync_alen (
    .clk_usb(clk_usb), .reset(reset), .d(cwusb_alen), .q(w_alen_s));

  logic [1:0]               r_state, w_state_nxt;
  logic                     r_stream, r_isout, r_reg_write, r_ffr_q, r_rdn_q;
  logic                     r_proto_err;
  logic [pADDR_WIDTH-1:0]   r_address;
  logic [pDATA_WIDTH-1:0]   r_datao;
  logic [pBYTECNT_SIZE-1:0] r_bytecnt;
  logic                     w_rd_raw, w_reg_read;

  logic w_wr_req, w_collide, w_ffr_rise, w_rd_done;
  assign w_wr_req   = ~w_wrn_s & ~cwusb_cen;
  assign w_collide  = ~w_rdn_s & ~w_wrn_s;
  assign w_ffr_rise = fast_fifo_read & ~r_ffr_q;
  // A read completes on the rising edge of the synchronized rdn while the
  // bus is in a read-capable state.
  assign w_rd_done  = w_rdn_s & ~r_rdn_q &
                      ((r_state == ST_READ) || (r_state == ST_STREAM));

  // Next-state logic; write requests take precedence everywhere.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_req)        w_state_nxt = ST_WRITE;
        else if (~w_rdn_s)   w_state_nxt = ST_READ;
        else if (w_ffr_rise) w_state_nxt = ST_STREAM;
        else                 w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (w_wrn_s) w_state_nxt = ST_IDLE;
        else         w_state_nxt = ST_WRITE;
      end
      ST_READ: begin
        if (w_wr_req && WR_OVER_RD) w_state_nxt = ST_WRITE;
        else if (w_rdn_s)           w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_READ;
      end
      ST_STREAM: begin
        // Leave streaming once the FIFO request drops and no read is open.
        if (w_wr_req)                        w_state_nxt = ST_WRITE;
        else if (~fast_fifo_read & w_rdn_s)  w_state_nxt = ST_IDLE;
        else                                 w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read strobe decode, suppressed on an rd/wr collision.
  always_comb begin
    w_rd_raw = 1'b0;
    case (r_state)
      ST_READ:   w_rd_raw = 1'b1;
      ST_STREAM: w_rd_raw = ~w_rdn_s & w_wrn_s;
      default:   w_rd_raw = 1'b0;
    endcase
    if (w_collide && WR_OVER_RD) w_reg_read = 1'b0;
    else                         w_reg_read = w_rd_raw;
  end

  // FSM state and bus-control registers.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_stream    <= 1'b0;
      r_isout     <= 1'b0;
      r_reg_write <= 1'b0;
      r_ffr_q     <= 1'b0;
      r_rdn_q     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_stream    <= (w_state_nxt == ST_STREAM);
      // High during READ and for one extra cycle after leaving it.
      r_isout     <= (w_state_nxt == ST_READ) || (r_state == ST_READ);
      r_reg_write <= (r_state == ST_WRITE) && w_wrn_s;
      r_ffr_q     <= fast_fifo_read;
      r_rdn_q     <= w_rdn_s;
    end
  end

  // Address, write-data capture, byte counter and sticky error flag.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      r_address   <= '0;
      r_datao     <= '0;
      r_bytecnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_address <= cwusb_addr;
      if ((r_state == ST_WRITE) && w_wr_req) r_datao <= cwusb_din;
      else                                   r_datao <= r_datao;
      // Address-latch low clears the index even if a transfer completes.
      if (~w_alen_s) begin
        r_bytecnt <= '0;
      end else if (r_reg_write || w_rd_done) begin
        if (r_bytecnt == BC_MAX) r_bytecnt <= BC_SAT ? BC_MAX : '0;
        else                     r_bytecnt <= r_bytecnt + BC_ONE;
      end else begin
        r_bytecnt <= r_bytecnt;
      end
      // A set in the same cycle wins over the clear.
      if (w_collide)          r_proto_err <= 1'b1;
      else if (proto_err_clr) r_proto_err <= 1'b0;
      else                    r_proto_err <= r_proto_err;
    end
  end

  assign cwusb_dout  = reg_datai;
  // Raw wrn releases the bus immediately when the host starts a write.
  assign cwusb_isout = r_isout | (r_stream & cwusb_wrn);
  assign reg_address = r_address;
  assign reg_bytecnt = r_bytecnt;
  assign reg_datao   = r_datao;
  assign reg_read    = w_reg_read;
  assign reg_write   = r_reg_write;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_usb_reg_bridge
// Directed bench for usb_reg_bridge (S = 2). Two extra instances with a
// 3-bit byte counter (wrap and saturate) share all inputs.
// -----------------------------------------------------------------------------
module tb_usb_reg_bridge;

  logic       clk_usb = 1'b0;
  logic       reset;
  logic [7:0] cwusb_din, cwusb_addr, reg_datai;
  logic       cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen;
  logic       fast_fifo_read, proto_err_clr;

  logic [7:0] cwusb_dout, reg_address, reg_datao;
  logic [6:0] reg_bytecnt;
  logic       cwusb_isout, reg_read, reg_write, proto_err;

  logic [7:0] w_dout, w_addr, w_datao, s_dout, s_addr, s_datao;
  logic [2:0] w_bc, s_bc;
  logic       w_isout, w_rd, w_wr, w_perr, s_isout, s_rd, s_wr, s_perr;

  int total = 0;
  int bad   = 0;

  always #5 clk_usb = ~clk_usb;

  usb_reg_bridge dut (
    .clk_usb(clk_usb), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(cwusb_dout),
    .cwusb_isout(cwusb_isout), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
    .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .cwusb_alen(cwusb_alen),
    .fast_fifo_read(fast_fifo_read), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read),
    .reg_write(reg_write), .proto_err(proto_err), .proto_err_clr(proto_err_clr));

  usb_reg_bridge #(.pBYTECNT_SIZE(3), .pBYTECNT_SAT(0)) dut_wrap (
    .clk_usb(clk_usb), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(w_dout),
    .cwusb_isout(w_isout), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
    .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .cwusb_alen(cwusb_alen),
    .fast_fifo_read(fast_fifo_read), .reg_address(w_addr), .reg_bytecnt(w_bc),
    .reg_datao(w_datao), .reg_datai(reg_datai), .reg_read(w_rd),
    .reg_write(w_wr), .proto_err(w_perr), .proto_err_clr(proto_err_clr));

  usb_reg_bridge #(.pBYTECNT_SIZE(3), .pBYTECNT_SAT(1)) dut_sat (
    .clk_usb(clk_usb), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(s_dout),
    .cwusb_isout(s_isout), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
    .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .cwusb_alen(cwusb_alen),
    .fast_fifo_read(fast_fifo_read), .reg_address(s_addr), .reg_bytecnt(s_bc),
    .reg_datao(s_datao), .reg_datai(reg_datai), .reg_read(s_rd),
    .reg_write(s_wr), .proto_err(s_perr), .proto_err_clr(proto_err_clr));

  task automatic step(input int n);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cwusb_din = 8'h00; cwusb_addr = 8'h12; reg_datai = 8'h3C;
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; cwusb_cen = 1'b1; cwusb_alen = 1'b1;
    fast_fifo_read = 1'b0; proto_err_clr = 1'b0;

    // Reset state
    step(2);
    check("rst_addr",  32'(reg_address), 32'h0);
    check("rst_bc",    32'(reg_bytecnt), 32'h0);
    check("rst_datao", 32'(reg_datao),   32'h0);
    check("rst_read",  32'(reg_read),    32'h0);
    check("rst_write", 32'(reg_write),   32'h0);
    check("rst_isout", 32'(cwusb_isout), 32'h0);
    check("rst_perr",  32'(proto_err),   32'h0);
    reset = 1'b0;
    step(1);

    // Single write: din 0xA5, wrn low 4 cycles
    cwusb_din = 8'hA5; cwusb_cen = 1'b0; cwusb_wrn = 1'b0;
    step(1);
    check("wr_addr", 32'(reg_address), 32'h12);
    step(3);
    cwusb_wrn = 1'b1;
    step(2);
    check("wr_early", 32'(reg_write), 32'h0);
    step(1);
    check("wr_pulse", 32'(reg_write), 32'h1);
    check("wr_datao", 32'(reg_datao), 32'hA5);
    check("wr_bc0",   32'(reg_bytecnt), 32'h0);
    step(1);
    check("wr_end",   32'(reg_write), 32'h0);
    check("wr_bc1",   32'(reg_bytecnt), 32'h1);
    cwusb_cen = 1'b1;

    // Read burst: alen clear, then 3 rdn pulses
    cwusb_alen = 1'b0;
    step(3);
    check("alen_clr", 32'(reg_bytecnt), 32'h0);
    cwusb_alen = 1'b1;
    step(3);
    for (int i = 0; i < 3; i++) begin
      cwusb_rdn = 1'b0;
      step(2);
      check("rd_early", 32'(reg_read), 32'h0);
      step(1);
      check("rd_on",    32'(reg_read), 32'h1);
      check("rd_oe_on", 32'(cwusb_isout), 32'h1);
      check("rd_dout",  32'(cwusb_dout), 32'h3C);
      step(2);
      cwusb_rdn = 1'b1;
      step(2);
      check("rd_hold",  32'(reg_read), 32'h1);
      step(1);
      check("rd_off",   32'(reg_read), 32'h0);
      check("rd_oe_hd", 32'(cwusb_isout), 32'h1);
      check("rd_bc",    32'(reg_bytecnt), 32'(i + 1));
      step(1);
      check("rd_oe_off", 32'(cwusb_isout), 32'h0);
    end
    cwusb_alen = 1'b0;
    step(3);
    check("rd_alen_clr", 32'(reg_bytecnt), 32'h0);
    cwusb_alen = 1'b1;
    step(3);

    // Byte-count boundary: 9 writes
    for (int i = 0; i < 9; i++) begin
      cwusb_din = 8'(i); cwusb_cen = 1'b0; cwusb_wrn = 1'b0;
      step(4);
      cwusb_wrn = 1'b1;
      step(4);
      cwusb_cen = 1'b1;
      step(1);
    end
    check("bc_main", 32'(reg_bytecnt), 32'h9);
    check("bc_wrap", 32'(w_bc), 32'h1);
    check("bc_sat",  32'(s_bc), 32'h7);

    // Stream mode
    fast_fifo_read = 1'b1;
    step(1);
    check("st_oe_on", 32'(cwusb_isout), 32'h1);
    check("st_read",  32'(reg_read), 32'h0);
    cwusb_din = 8'h5A; cwusb_cen = 1'b0; cwusb_wrn = 1'b0;
    #1;
    check("st_oe_comb", 32'(cwusb_isout), 32'h0);
    step(3);
    cwusb_wrn = 1'b1;
    #1;
    check("st_left", 32'(cwusb_isout), 32'h0);
    step(3);
    check("st_write", 32'(reg_write), 32'h1);
    check("st_datao", 32'(reg_datao), 32'h5A);
    step(1);
    cwusb_cen = 1'b1; fast_fifo_read = 1'b0;
    step(2);

    // Protocol error: collision during a write
    cwusb_din = 8'h77; cwusb_cen = 1'b0; cwusb_rdn = 1'b0; cwusb_wrn = 1'b0;
    step(3);
    check("pe_set",  32'(proto_err), 32'h1);
    check("pe_read", 32'(reg_read), 32'h0);
    step(1);
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1;
    step(3);
    check("pe_write", 32'(reg_write), 32'h1);
    check("pe_datao", 32'(reg_datao), 32'h77);
    step(1);
    cwusb_cen = 1'b1; proto_err_clr = 1'b1;
    step(1);
    check("pe_clr", 32'(proto_err), 32'h0);
    // Collision with clear held: set wins, read suppressed in READ
    cwusb_rdn = 1'b0; cwusb_wrn = 1'b0;
    step(3);
    check("pe_setwin", 32'(proto_err), 32'h1);
    check("pe_rdsupp", 32'(reg_read), 32'h0);
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1;
    step(4);
    check("pe_clr2", 32'(proto_err), 32'h0);
    proto_err_clr = 1'b0;
    step(2);

    // Reset during READ
    cwusb_rdn = 1'b0;
    step(3);
    check("rr_read", 32'(reg_read), 32'h1);
    reset = 1'b1;
    step(1);
    check("rr_read0", 32'(reg_read), 32'h0);
    check("rr_oe0",   32'(cwusb_isout), 32'h0);
    check("rr_bc0",   32'(reg_bytecnt), 32'h0);
    cwusb_rdn = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);
    check("rr_noinc", 32'(reg_bytecnt), 32'h0);
    check("rr_idle",  32'(reg_read), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
